sw_target_feeder: RTL and testbench

- Upstream stage of the Smith-Waterman scoring array: takes the target sequence as packed words over a valid/ready stream and serializes it into one 2-bit base per clock.
- Drives the array's enable input and base input.
- Holds the query length as the array's output-select for the whole sequence.
- Sequences one alignment job: start, feed, drain, done. It flags a job error when the input stream underruns mid-sequence or the query length is illegal.

---
 rtl/sw_target_feeder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sw_target_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_target_feeder.sv
// ============================================================================
// sw_target_feeder
// ----------------------------------------------------------------------------
// Upstream stage of the Smith-Waterman scoring array. Accepts the target
// sequence as packed words on a valid/ready stream and presents it to the
// array as one 2-bit base per clock. It holds the query length on the array's
// output-select for the whole job. Each job runs IDLE -> LOAD -> FEED ->
// DRAIN -> IDLE. An input underrun mid-sequence or an illegal query length
// raises an error pulse.
//
// Parameters
//   LENGTH       number of processing elements in the downstream array
//   LOG_LENGTH   width of q_len / output_select (holds 0..LENGTH)
//   WORD_BASES   bases packed per input word (power of two, >= 2)
//   TLEN_WIDTH   width of the target-length field
//   DRAIN_EXTRA  cycles added to q_len for array pipeline + result register
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous reset, active-low
//   start          in   one-cycle job request, sampled only in IDLE
//   tgt_len        in   target length in bases, sampled with start
//   q_len          in   query length in bases, sampled with start
//   s_valid        in   input word valid
//   s_ready        out  input word accepted when s_valid & s_ready
//   s_data         in   packed bases, base 0 in bits [1:0]
//   en_out         out  array enable, high while a base is presented
//   data_out       out  current base to the array
//   output_select  out  latched q_len for the array result mux
//   busy           out  high in any state other than IDLE
//   done           out  one-cycle pulse at job end
//   err            out  one-cycle pulse on job error
//
// Optional feature (macro SW_FEEDER_JOBCNT_EN)
//   job_count_clr  in   synchronous clear of job_count (wins over increment)
//   job_count      out  16-bit count of jobs that completed without error
// ============================================================================
module sw_target_feeder #(
    parameter int LENGTH      = 128,
    parameter int LOG_LENGTH  = 8,
    parameter int WORD_BASES  = 4,
    parameter int TLEN_WIDTH  = 16,
    parameter int DRAIN_EXTRA = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [TLEN_WIDTH-1:0]   tgt_len,
    input  logic [LOG_LENGTH-1:0]   q_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [2*WORD_BASES-1:0] s_data,
    output logic                    en_out,
    output logic [1:0]              data_out,
    output logic [LOG_LENGTH-1:0]   output_select,
    output logic                    busy,
    output logic                    done,
    output logic                    err
`ifdef SW_FEEDER_JOBCNT_EN
    ,
    input  logic                    job_count_clr,
    output logic [15:0]             job_count
`endif
);

    localparam int WORD_W  = 2 * WORD_BASES;
    localparam int IDX_W   = (WORD_BASES > 1) ? $clog2(WORD_BASES) : 1;
    localparam int DRAIN_W = $clog2((2 ** LOG_LENGTH) + DRAIN_EXTRA + 1);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_BASES - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [TLEN_WIDTH-1:0] REM_ONE  = TLEN_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]    DRN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0]    DRN_XTRA = DRAIN_W'(DRAIN_EXTRA);
    localparam logic [LOG_LENGTH:0]   MAX_Q    = (LOG_LENGTH + 1)'(LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FEED  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A query must occupy at least one PE and no more than the array holds.
    function automatic logic q_len_legal(input logic [LOG_LENGTH-1:0] q);
        return (q != '0) && ({1'b0, q} <= MAX_Q);
    endfunction

    state_t                  state, nxt_state;
    logic [TLEN_WIDTH-1:0]   rem, nxt_rem;
    logic [IDX_W-1:0]        base_idx, nxt_base_idx;
    logic [WORD_W-1:0]       shreg, nxt_shreg;
    logic [DRAIN_W-1:0]      drain_cnt, nxt_drain_cnt;
    logic                    en_r, nxt_en;
    logic [1:0]              dout_r, nxt_dout;
    logic [LOG_LENGTH-1:0]   osel_r, nxt_osel;
    logic                    done_r, nxt_done;
    logic                    err_r, nxt_err;
    logic                    s_ready_c;
    logic                    at_boundary;
    logic [DRAIN_W-1:0]      drain_load;

    // Word boundary: the last base of the current word is on the output and
    // more bases are still owed, so the next word must arrive this cycle.
    assign at_boundary = (base_idx == LAST_IDX) && (rem > REM_ONE);
    assign drain_load  = DRAIN_W'(osel_r) + DRN_XTRA;

    always_comb begin
        nxt_state     = state;
        nxt_rem       = rem;
        nxt_base_idx  = base_idx;
        nxt_shreg     = shreg;
        nxt_drain_cnt = drain_cnt;
        nxt_en        = en_r;
        nxt_dout      = dout_r;
        nxt_osel      = osel_r;
        nxt_done      = 1'b0;
        nxt_err       = 1'b0;
        s_ready_c     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (!q_len_legal(q_len)) begin
                        nxt_err  = 1'b1;
                        nxt_done = 1'b1;
                    end else if (tgt_len == '0) begin
                        nxt_done = 1'b1;
                        nxt_osel = q_len;
                    end else begin
                        nxt_rem   = tgt_len;
                        nxt_osel  = q_len;
                        nxt_state = LOAD;
                    end
                end
            end

            LOAD: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    // Base 0 goes straight to the output register; the
                    // remaining bases wait in the shift register.
                    nxt_dout     = s_data[1:0];
                    nxt_shreg    = s_data >> 2;
                    nxt_base_idx = '0;
                    nxt_en       = 1'b1;
                    nxt_state    = FEED;
                end
            end

            FEED: begin
                s_ready_c = at_boundary;
                if (rem <= REM_ONE) begin
                    // Last base is on the output now; leftover bases of the
                    // final word are simply dropped.
                    nxt_rem       = '0;
                    nxt_en        = 1'b0;
                    nxt_dout      = 2'b00;
                    nxt_drain_cnt = drain_load;
                    nxt_state     = DRAIN;
                end else if (at_boundary) begin
                    if (s_valid) begin
                        nxt_dout     = s_data[1:0];
                        nxt_shreg    = s_data >> 2;
                        nxt_base_idx = '0;
                        nxt_rem      = rem - REM_ONE;
                    end else begin
                        // Underrun: bases fed so far stand as the sequence.
                        nxt_err       = 1'b1;
                        nxt_en        = 1'b0;
                        nxt_dout      = 2'b00;
                        nxt_drain_cnt = drain_load;
                        nxt_state     = DRAIN;
                    end
                end else begin
                    nxt_dout     = shreg[1:0];
                    nxt_shreg    = shreg >> 2;
                    nxt_base_idx = base_idx + IDX_ONE;
                    nxt_rem      = rem - REM_ONE;
                end
            end

            DRAIN: begin
                // Count reaches zero on the same edge that raises done and
                // returns to IDLE, so busy is already low while done is high.
                nxt_drain_cnt = drain_cnt - DRN_ONE;
                if (drain_cnt <= DRN_ONE) begin
                    nxt_drain_cnt = '0;
                    nxt_done      = 1'b1;
                    nxt_state     = IDLE;
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rem       <= '0;
            base_idx  <= '0;
            shreg     <= '0;
            drain_cnt <= '0;
            en_r      <= 1'b0;
            dout_r    <= 2'b00;
            osel_r    <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= nxt_state;
            rem       <= nxt_rem;
            base_idx  <= nxt_base_idx;
            shreg     <= nxt_shreg;
            drain_cnt <= nxt_drain_cnt;
            en_r      <= nxt_en;
            dout_r    <= nxt_dout;
            osel_r    <= nxt_osel;
            done_r    <= nxt_done;
            err_r     <= nxt_err;
        end
    end

    assign s_ready       = s_ready_c;
    assign en_out        = en_r;
    assign data_out      = dout_r;
    assign output_select = osel_r;
    assign busy          = (state != IDLE);
    assign done          = done_r;
    assign err           = err_r;

`ifdef SW_FEEDER_JOBCNT_EN
    // An underrun raises err long before done, so remember it for the job.
    logic        job_err;
    logic [15:0] job_cnt_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            job_err <= 1'b0;
        end else if ((state == FEED) && nxt_err) begin
            job_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt_r <= '0;
        end else if (job_count_clr) begin
            job_cnt_r <= '0;
        end else if (done_r && !err_r && !job_err) begin
            job_cnt_r <= job_cnt_r + 16'd1;
        end
    end

    assign job_count = job_cnt_r;
`endif

endmodule

// File: tb/tb_sw_target_feeder.sv
module tb_sw_target_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] tgt_len;
    logic [7:0]  q_len;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        en_out;
    logic [1:0]  data_out;
    logic [7:0]  output_select;
    logic        busy;
    logic        done;
    logic        err;
`ifdef SW_FEEDER_JOBCNT_EN
    logic        job_count_clr;
    logic [15:0] job_count;
`endif

    sw_target_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tgt_len       (tgt_len),
        .q_len         (q_len),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .en_out        (en_out),
        .data_out      (data_out),
        .output_select (output_select),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef SW_FEEDER_JOBCNT_EN
        ,
        .job_count_clr (job_count_clr),
        .job_count     (job_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Cycle monitor, sampled on the falling edge.
    int         cyc = 0;
    int         en_cnt, gaps, hs, rdy_cnt, done_cnt, err_cnt;
    int         fall_cyc, done_cyc, err_cyc;
    logic       done_busy;
    logic       prev_en;
    logic [1:0] bases[$];

    always @(negedge clk) begin
        cyc++;
        if (en_out) begin
            if (!prev_en && en_cnt > 0) gaps++;
            bases.push_back(data_out);
            en_cnt++;
        end
        if (!en_out && prev_en) fall_cyc = cyc;
        prev_en = en_out;
        if (s_valid && s_ready) hs++;
        if (s_ready) rdy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic clear_mon();
        en_cnt = 0; gaps = 0; hs = 0; rdy_cnt = 0; done_cnt = 0; err_cnt = 0;
        fall_cyc = -1; done_cyc = -1; err_cyc = -1; done_busy = 1'bx;
        prev_en = 1'b0;
        bases.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] packed_bases();
        logic [31:0] pk = 32'h0;
        for (int i = 0; i < bases.size() && i < 16; i++)
            pk = pk | (32'(bases[i]) << (2 * i));
        return pk;
    endfunction

    // Issue a start pulse; returns one cycle after the sampling edge.
    task automatic do_start(input logic [15:0] tl, input logic [7:0] ql);
        start = 1'b1; tgt_len = tl; q_len = ql;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word until accepted (bounded).
    task automatic send_word(input logic [7:0] w);
        int n = 0;
        s_valid = 1'b1; s_data = w;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hs_wait", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; tgt_len = 0; q_len = 0; s_valid = 0; s_data = 0;
`ifdef SW_FEEDER_JOBCNT_EN
        job_count_clr = 0;
`endif
        clear_mon();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        // Reset state
        chk("rst_en", 32'(en_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_osel", 32'(output_select), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Basic feed: 6 bases from 0xE4, 0x0B -> 0,1,2,3,3,2
        clear_mon();
        do_start(16'd6, 8'd3);
        chk("t1_busy_load", 32'(busy), 32'd1);
        chk("t1_ready_load", 32'(s_ready), 32'd1);
        send_word(8'hE4);
        send_word(8'h0B);
        wait_done();
        chk("t1_en_cnt", 32'(en_cnt), 32'd6);
        chk("t1_bases", packed_bases(), 32'h0000_0BE4);
        chk("t1_gaps", 32'(gaps), 32'd0);
        chk("t1_osel", 32'(output_select), 32'd3);
        chk("t1_done_lat", 32'(done_cyc - fall_cyc), 32'd5);
        chk("t1_busy_at_done", 32'(done_busy), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);
        chk("t1_hs", 32'(hs), 32'd2);

        // Back-to-back words, 12 bases
        clear_mon();
        do_start(16'd12, 8'd7);
        send_word(8'h1B);
        send_word(8'hE4);
        send_word(8'h9C);
        wait_done();
        chk("t2_en_cnt", 32'(en_cnt), 32'd12);
        chk("t2_gaps", 32'(gaps), 32'd0);
        chk("t2_bases", packed_bases(), 32'h009C_E41B);
        chk("t2_hs", 32'(hs), 32'd3);
        chk("t2_ready_cnt", 32'(rdy_cnt), 32'd3);
        chk("t2_osel", 32'(output_select), 32'd7);
        chk("t2_done_lat", 32'(done_cyc - fall_cyc), 32'd9);

        // Underrun: second word withheld
        clear_mon();
        do_start(16'd8, 8'd4);
        send_word(8'hE4);
        wait_done();
        chk("t3_en_cnt", 32'(en_cnt), 32'd4);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        chk("t3_err_vs_fall", 32'(err_cyc - fall_cyc), 32'd0);
        chk("t3_done_lat", 32'(done_cyc - err_cyc), 32'd6);
        chk("t3_ready_cnt", 32'(rdy_cnt), 32'd2);
        chk("t3_hs", 32'(hs), 32'd1);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Illegal and empty jobs
        do_start(16'd5, 8'd0);
        chk("t4a_done", 32'(done), 32'd1);
        chk("t4a_err", 32'(err), 32'd1);
        chk("t4a_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("t4a_done_off", 32'(done), 32'd0);
        chk("t4a_osel", 32'(output_select), 32'd4);
        do_start(16'd5, 8'd129);
        chk("t4b_done", 32'(done), 32'd1);
        chk("t4b_err", 32'(err), 32'd1);
        chk("t4b_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_start(16'd0, 8'd5);
        chk("t4c_done", 32'(done), 32'd1);
        chk("t4c_err", 32'(err), 32'd0);
        chk("t4c_busy", 32'(busy), 32'd0);
        chk("t4c_osel", 32'(output_select), 32'd5);
        do_start(16'd0, 8'd128);
        chk("t4d_done", 32'(done), 32'd1);
        chk("t4d_err", 32'(err), 32'd0);
        chk("t4d_osel", 32'(output_select), 32'd128);
        @(posedge clk); #1;

        // start during FEED ignored, then reset mid-FEED
        clear_mon();
        do_start(16'd12, 8'd6);
        send_word(8'hE4);
        chk("t5_en_feed", 32'(en_out), 32'd1);
        do_start(16'd3, 8'd9);
        chk("t5_osel_hold", 32'(output_select), 32'd6);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_data", 32'(data_out), 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_rst_en", 32'(en_out), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        chk("t5_no_err", 32'(err_cnt), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

`ifdef SW_FEEDER_JOBCNT_EN
        chk("t6_cnt_rst", 32'(job_count), 32'd0);
        for (int j = 0; j < 3; j++) begin
            clear_mon();
            do_start(16'd4, 8'd1);
            send_word(8'h1B);
            wait_done();
        end
        chk("t6_cnt3", 32'(job_count), 32'd3);
        clear_mon();
        do_start(16'd8, 8'd1);
        send_word(8'h1B);
        wait_done();
        chk("t6_underrun_cnt", 32'(job_count), 32'd3);
        do_start(16'd4, 8'd0);
        @(posedge clk); #1;
        chk("t6_illegal_cnt", 32'(job_count), 32'd3);
        do_start(16'd0, 8'd2);
        chk("t6_done_now", 32'(done), 32'd1);
        job_count_clr = 1'b1;
        @(posedge clk); #1;
        job_count_clr = 1'b0;
        chk("t6_clr_wins", 32'(job_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
